param_ring_counter: RTL
=======================

PARAM_RING_COUNTER -- requirements
Module: param_ring_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter length in bits; legal range 2..32.
REQ-002 Parameter JOHNSON, default 0, SHALL select the mode: 0 = one-hot ring, 1 = Johnson (twisted ring).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port en  input  1  SHALL enable one shift per cycle when high.
REQ-006 Port dir  input  1  SHALL select the shift direction: 0 = toward MSB, 1 = toward LSB.
REQ-007 Port load  input  1  SHALL load load_val into Q when high.
REQ-008 Port load_val  input  WIDTH  SHALL be the parallel load value.
REQ-009 Port Q  output  WIDTH  SHALL be the registered counter state.
REQ-010 Port wrap  output  1  SHALL be a registered one-cycle pulse marking return to the home state.
REQ-011 Port err  output  1  SHALL be a registered one-cycle pulse marking a corrected illegal state; the port is always present.

Function
REQ-012 The home state SHALL be 0...01 when JOHNSON=0 and all-zeros when JOHNSON=1.
REQ-013 Ring, dir=0: Q SHALL become {Q[WIDTH-2:0], Q[WIDTH-1]}. Ring, dir=1: Q SHALL become {Q[0], Q[WIDTH-1:1]}.
REQ-014 Johnson, dir=0: Q SHALL become {Q[WIDTH-2:0], ~Q[WIDTH-1]}. Johnson, dir=1: Q SHALL become {~Q[0], Q[WIDTH-1:1]}.
REQ-015 Update priority per edge SHALL be reset > load > illegal-state correction (if compiled in) > shift (en=1) > hold.
REQ-016 With en=0, load=0 and no correction, Q SHALL hold; dir SHALL have no effect.
REQ-017 A shift SHALL take effect on the edge where en is sampled high; Q latency is 1 cycle.
REQ-018 wrap SHALL be 1 in exactly the cycle after a shift edge that produces the home state; otherwise 0.
REQ-019 wrap SHALL be 0 after a load, a reset, or a correction, even if the resulting Q equals the home state.
REQ-020 dir MAY change on any cycle; each shift SHALL use the dir value sampled on its own edge.
REQ-021 Legal states: ring = exactly one bit set; Johnson = one of the 2*WIDTH states reachable from all-zeros.
REQ-022 load together with en on the same edge SHALL load only; the shift starts on the next enabled edge.
REQ-023 err SHALL be 0 whenever the correction feature is compiled out.

Reset
REQ-024 On an edge with reset=1, Q SHALL become the home state, wrap SHALL be 0 and err SHALL be 0, regardless of en, load and dir.
REQ-025 Reset asserted mid-sequence SHALL abandon the current state; counting SHALL resume from the home state on the first enabled edge after release.

Configuration
REQ-026 Macro RING_SELF_CORRECT_EN, when defined, SHALL compile in illegal-state correction.
REQ-027 With the macro defined: on an edge with reset=0 and load=0 and Q illegal, Q SHALL become the home state and err SHALL pulse for 1 cycle.
REQ-028 With the macro defined: a load with an illegal load_val SHALL set Q to the home state and pulse err.
REQ-029 Without the macro, illegal values SHALL be loaded as given and circulated unchanged by the shift rules, and err SHALL stay 0.

Verification (WIDTH=4)
REQ-030 Ring: reset for 2 cycles, then en=1, dir=0 -> Q sequence 0001, 0010, 0100, 1000, 0001; wrap=1 only in the cycle Q re-reads 0001.
REQ-031 Ring: en=1, dir=1 from reset -> Q sequence 0001, 1000, 0100, 0010, 0001; wrap pulses on the return to 0001.
REQ-032 Johnson: en=1, dir=0 -> Q sequence 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap pulses once per 8 shifts.
REQ-033 Ring: load=1, load_val=0100, en=1 on the same edge -> Q=0100, wrap=0; next edge -> Q=1000.
REQ-034 Ring: load_val=0110 -> with the macro defined, Q=0001 and err=1 for one cycle; without the macro, Q sequence 0110, 1100, 1001 and err=0.
REQ-035 Reset asserted when Q=0100 with en=1 -> Q=0001, wrap=0, err=0 on the next edge; the first enabled edge after release gives Q=0010.

Source files
------------

// File: rtl/param_ring_counter.sv
// ---------------------------------------------------------------------------
// param_ring_counter
//
// Parameterised shift counter. JOHNSON=0 builds a one-hot ring counter whose
// home state is 0...01; JOHNSON=1 builds a Johnson (twisted ring) counter
// whose home state is all-zeros and which cycles through 2*WIDTH states.
//
// Optional feature (compile-time macro RING_SELF_CORRECT_EN):
//   when defined, any illegal state held in Q, or any illegal value
//   presented on a load, is replaced by the home state and err pulses for
//   one cycle. When undefined, illegal values are loaded and circulated
//   unchanged and err is held at 0.
//
// Parameters:
//   WIDTH    counter length in bits (2..32)
//   JOHNSON  0 = one-hot ring, 1 = Johnson
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (Q <= home, wrap/err <= 0)
//   en        one shift per cycle when high
//   dir       0 = shift toward MSB, 1 = shift toward LSB
//   load      load load_val into Q (wins over en on the same edge)
//   load_val  parallel load value
//   Q         registered counter state
//   wrap      registered pulse: the previous edge shifted into home state
//   err       registered pulse: the previous edge corrected an illegal state
// ---------------------------------------------------------------------------
module param_ring_counter #(
    parameter int WIDTH   = 4,
    parameter bit JOHNSON = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] HOME = JOHNSON ? '0 : WIDTH'(1);

    // One shift step in the selected mode and direction.
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] v,
                                                    input logic d);
        logic [WIDTH-1:0] r;
        if (JOHNSON) begin
            r = d ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
        end else begin
            r = d ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
        end
        return r;
    endfunction

`ifdef RING_SELF_CORRECT_EN
    // Ring: exactly one bit set.
    // Johnson: the reachable states are a run of ones anchored at the LSB
    // (0..01..1) or a run of ones anchored at the MSB (1..10..0). A value of
    // the first form satisfies v & (v+1) == 0; the second form is the
    // complement of the first.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] inv;
        logic             ok;
        inv = ~v;
        if (JOHNSON) begin
            ok = ((v & (v + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
        end else begin
            ok = $onehot(v);
        end
        return ok;
    endfunction
`endif

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_shift;
    logic             wrap_next;
    logic             err_next;

    assign q_shift = shift_next(Q, dir);

    // Priority below reset: load > correction (if compiled in) > shift > hold.
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            q_next = load_val;
`ifdef RING_SELF_CORRECT_EN
            if (!is_legal(load_val)) begin
                q_next   = HOME;
                err_next = 1'b1;
            end
`endif
        end
`ifdef RING_SELF_CORRECT_EN
        else if (!is_legal(Q)) begin
            q_next   = HOME;
            err_next = 1'b1;
        end
`endif
        else if (en) begin
            q_next    = q_shift;
            // Only a shift into home counts as a wrap; loads and
            // corrections that land on home do not.
            wrap_next = (q_shift == HOME);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q    <= HOME;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

endmodule
